mem_stage: RTL and testbench

Memory-access stage of the 5-stage pipeline CPU. Consumes the EX/MEM pipeline register outputs and resolves the branch decision. Drives a request/acknowledge data-memory bus for lw/sw, stalling the front of the pipeline while an access is outstanding. Registers results into the MEM/WB pipeline register.

---
 rtl/mem_stage_pkg.sv | 39 +++
 rtl/mem_stage_mem_wb.sv | 69 ++++++
 rtl/mem_stage.sv | 168 ++++++++++++++++
 tb/tb_mem_stage.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the MEM stage slice.
//   - MEM_control bit indices (Branch / MemRead / MemWrite)
//   - WB_control and MEM_control widths
//   - FSM state encoding for the data-memory handshake
//   - access-type decode helper (write wins over read)
package mem_stage_pkg;

  localparam int unsigned MEM_BRANCH = 2;
  localparam int unsigned MEM_READ   = 1;
  localparam int unsigned MEM_WRITE  = 0;

  localparam int unsigned MEM_CTRL_W = 3;
  localparam int unsigned WB_CTRL_W  = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  typedef enum logic [1:0] {
    ACC_NONE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2
  } mem_access_e;

  // MemWrite takes priority when both control bits are set.
  function automatic mem_access_e decode_access(input logic mem_read,
                                                input logic mem_write);
    mem_access_e acc;
    acc = ACC_NONE;
    if (mem_write) begin
      acc = ACC_WRITE;
    end else if (mem_read) begin
      acc = ACC_READ;
    end
    return acc;
  endfunction

endpackage

// File: rtl/mem_stage_mem_wb.sv
// R_MEM_WB: MEM/WB pipeline register.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset (all fields to 0)
//   i_bubble          load a bubble: WB_control cleared, other fields held
//   i_rdata_en        load i_read_data into the read-data field (read completion)
//   i_alu_result      ALU result to register
//   i_read_data       memory read data
//   i_write_reg       destination register
//   i_WB_control      WB control bits
//   o_*               registered fields
module R_MEM_WB
  import mem_stage_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_bubble,
  input  logic                 i_rdata_en,
  input  logic [31:0]          i_alu_result,
  input  logic [31:0]          i_read_data,
  input  logic [4:0]           i_write_reg,
  input  logic [WB_CTRL_W-1:0] i_WB_control,
  output logic [31:0]          o_read_data,
  output logic [31:0]          o_alu_result,
  output logic [4:0]           o_write_reg,
  output logic [WB_CTRL_W-1:0] o_WB_control
);

  logic [31:0]          read_data_q, read_data_d;
  logic [31:0]          alu_result_q, alu_result_d;
  logic [4:0]           write_reg_q, write_reg_d;
  logic [WB_CTRL_W-1:0] wb_ctrl_q, wb_ctrl_d;

  always_comb begin
    read_data_d  = read_data_q;
    alu_result_d = alu_result_q;
    write_reg_d  = write_reg_q;
    wb_ctrl_d    = wb_ctrl_q;
    if (i_bubble) begin
      wb_ctrl_d = '0;
    end else begin
      wb_ctrl_d    = i_WB_control;
      write_reg_d  = i_write_reg;
      alu_result_d = i_alu_result;
      if (i_rdata_en) begin
        read_data_d = i_read_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      read_data_q  <= '0;
      alu_result_q <= '0;
      write_reg_q  <= '0;
      wb_ctrl_q    <= '0;
    end else begin
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      write_reg_q  <= write_reg_d;
      wb_ctrl_q    <= wb_ctrl_d;
    end
  end

  assign o_read_data  = read_data_q;
  assign o_alu_result = alu_result_q;
  assign o_write_reg  = write_reg_q;
  assign o_WB_control = wb_ctrl_q;

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage pipeline.
// Resolves the branch decision, drives a req/ack data-memory bus for lw/sw,
// stalls the front of the pipeline while an access is outstanding, and
// registers results into MEM/WB (R_MEM_WB).
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_branch_pc/i_result/i_zero/i_read_data2/i_write_reg/i_WB_control/
//   i_MEM_control           EX/MEM pipeline register outputs
//   i_dmem_ack/i_dmem_rdata data-memory response
//   o_dmem_req/we/addr/wdata data-memory request (combinational)
//   o_pc_src/o_branch_pc    branch decision
//   o_stall                 freeze PC, IF/ID, ID/EX, EX/MEM
//   o_misalign/o_bus_err    registered one-cycle error pulses
//   o_read_data/o_alu_result/o_write_reg/o_WB_control  MEM/WB register
// Configuration:
//   MEM_TIMEOUT_EN  when defined, a request that sees no ack for
//                   TIMEOUT_CYCLES consecutive request cycles is abandoned and
//                   o_bus_err pulses; when undefined, WAIT persists and
//                   o_bus_err is tied to 0.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [31:0]           i_branch_pc,
  input  logic [31:0]           i_result,
  input  logic                  i_zero,
  input  logic [31:0]           i_read_data2,
  input  logic [4:0]            i_write_reg,
  input  logic [WB_CTRL_W-1:0]  i_WB_control,
  input  logic [MEM_CTRL_W-1:0] i_MEM_control,
  input  logic                  i_dmem_ack,
  input  logic [31:0]           i_dmem_rdata,
  output logic                  o_dmem_req,
  output logic                  o_dmem_we,
  output logic [31:0]           o_dmem_addr,
  output logic [31:0]           o_dmem_wdata,
  output logic                  o_pc_src,
  output logic [31:0]           o_branch_pc,
  output logic                  o_stall,
  output logic                  o_misalign,
  output logic                  o_bus_err,
  output logic [31:0]           o_read_data,
  output logic [31:0]           o_alu_result,
  output logic [4:0]            o_write_reg,
  output logic [WB_CTRL_W-1:0]  o_WB_control
);

  mem_state_e  state_q, state_d;
  mem_access_e access;
  logic        access_req;
  logic        aligned;
  logic        mem_op;
  logic        req;
  logic        done;
  logic        timeout;
  logic        misalign_d, misalign_q;
  logic        bus_err_q;
  logic        bubble;
  logic        rdata_en;

  assign access     = decode_access(i_MEM_control[MEM_READ], i_MEM_control[MEM_WRITE]);
  assign access_req = (access != ACC_NONE);
  assign aligned    = (i_result[1:0] == 2'b00);
  assign mem_op     = access_req & aligned;

  // In WAIT the EX/MEM register is frozen, so the request stays asserted
  // without re-qualifying it against the inputs.
  assign req  = (state_q == ST_WAIT) | ((state_q == ST_IDLE) & mem_op);
  assign done = req & i_dmem_ack;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  // cnt_q holds the number of request cycles already spent on the current
  // access (0 in IDLE), so the timeout fires in the TIMEOUT_CYCLES-th cycle.
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout = req & ~i_dmem_ack & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    if (state_d == ST_WAIT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // TIMEOUT_CYCLES only matters when the timeout feature is built in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_op && !i_dmem_ack && !timeout) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_dmem_ack || timeout) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      misalign_q <= misalign_d;
      bus_err_q  <= timeout;
    end
  end

  // A misaligned access never issues a request, so it never stalls; each
  // cycle in IDLE therefore carries a fresh instruction and the pulse cannot
  // repeat for the same access.
  assign misalign_d = (state_q == ST_IDLE) & access_req & ~aligned;

  assign o_stall  = req & ~i_dmem_ack & ~timeout;
  assign bubble   = o_stall | misalign_d | timeout;
  assign rdata_en = done & (access == ACC_READ);

  assign o_dmem_req   = req;
  assign o_dmem_we    = (access == ACC_WRITE);
  assign o_dmem_addr  = i_result;
  assign o_dmem_wdata = i_read_data2;

  assign o_pc_src    = i_MEM_control[MEM_BRANCH] & i_zero;
  assign o_branch_pc = i_branch_pc;

  assign o_misalign = misalign_q;
  assign o_bus_err  = bus_err_q;

  R_MEM_WB u_mem_wb (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_bubble     (bubble),
    .i_rdata_en   (rdata_en),
    .i_alu_result (i_result),
    .i_read_data  (i_dmem_rdata),
    .i_write_reg  (i_write_reg),
    .i_WB_control (i_WB_control),
    .o_read_data  (o_read_data),
    .o_alu_result (o_alu_result),
    .o_write_reg  (o_write_reg),
    .o_WB_control (o_WB_control)
  );

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed, table-driven bench for mem_stage, plus hand-written
// sequences for multi-cycle stalls, reset during WAIT and the timeout option.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_branch_pc, i_result, i_read_data2, i_dmem_rdata;
  logic        i_zero, i_dmem_ack;
  logic [4:0]  i_write_reg;
  logic [1:0]  i_WB_control;
  logic [2:0]  i_MEM_control;

  logic        o_dmem_req, o_dmem_we, o_pc_src, o_stall, o_misalign, o_bus_err;
  logic [31:0] o_dmem_addr, o_dmem_wdata, o_branch_pc, o_read_data, o_alu_result;
  logic [4:0]  o_write_reg;
  logic [1:0]  o_WB_control;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_branch_pc  (i_branch_pc),
    .i_result     (i_result),
    .i_zero       (i_zero),
    .i_read_data2 (i_read_data2),
    .i_write_reg  (i_write_reg),
    .i_WB_control (i_WB_control),
    .i_MEM_control(i_MEM_control),
    .i_dmem_ack   (i_dmem_ack),
    .i_dmem_rdata (i_dmem_rdata),
    .o_dmem_req   (o_dmem_req),
    .o_dmem_we    (o_dmem_we),
    .o_dmem_addr  (o_dmem_addr),
    .o_dmem_wdata (o_dmem_wdata),
    .o_pc_src     (o_pc_src),
    .o_branch_pc  (o_branch_pc),
    .o_stall      (o_stall),
    .o_misalign   (o_misalign),
    .o_bus_err    (o_bus_err),
    .o_read_data  (o_read_data),
    .o_alu_result (o_alu_result),
    .o_write_reg  (o_write_reg),
    .o_WB_control (o_WB_control)
  );

  typedef struct {
    logic [2:0]  ctrl;
    logic [31:0] result;
    logic [31:0] wdata;
    logic        zero;
    logic [31:0] bpc;
    logic [4:0]  wreg;
    logic [1:0]  wb;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_we;
    logic        e_stall;
    logic        e_pcsrc;
    logic [1:0]  e_wb;
    logic [4:0]  e_wreg;
    logic [31:0] e_alu;
    logic [31:0] e_rd;
    logic        e_mis;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input logic [2:0] ctrl, input logic [31:0] res, input logic [31:0] wd,
                       input logic z, input logic [31:0] bpc, input logic [4:0] wr,
                       input logic [1:0] wb, input logic ack, input logic [31:0] rd);
    i_MEM_control = ctrl;
    i_result      = res;
    i_read_data2  = wd;
    i_zero        = z;
    i_branch_pc   = bpc;
    i_write_reg   = wr;
    i_WB_control  = wb;
    i_dmem_ack    = ack;
    i_dmem_rdata  = rd;
  endtask

  task automatic drive_idle();
    drive(3'b000, 32'h0, 32'h0, 1'b0, 32'h0, 5'd0, 2'b00, 1'b0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ctrl, result, wdata, zero, bpc, wreg, wb, ack, rdata |
    // req, we, stall, pcsrc | wb, wreg, alu, rd, mis (after the edge)
    vecs[0] = '{3'b010, 32'h10, 32'h0, 1'b0, 32'h100, 5'd8, 2'b11, 1'b1, 32'hDEADBEEF,
                1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 5'd8, 32'h10, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{3'b000, 32'h55, 32'h9999, 1'b0, 32'h200, 5'd3, 2'b10, 1'b1, 32'hBAD0BAD0,
                1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd3, 32'h55, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{3'b001, 32'h40, 32'hCAFEF00D, 1'b0, 32'h300, 5'd0, 2'b00, 1'b1, 32'h11111111,
                1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 5'd0, 32'h40, 32'hDEADBEEF, 1'b0};
    vecs[3] = '{3'b011, 32'h44, 32'h0BADC0DE, 1'b0, 32'h400, 5'd5, 2'b01, 1'b1, 32'h22222222,
                1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 5'd5, 32'h44, 32'hDEADBEEF, 1'b0};
    vecs[4] = '{3'b010, 32'h22, 32'h0, 1'b0, 32'h500, 5'd9, 2'b11, 1'b0, 32'h33333333,
                1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd5, 32'h44, 32'hDEADBEEF, 1'b1};
    vecs[5] = '{3'b100, 32'h0, 32'h0, 1'b1, 32'h10000040, 5'd0, 2'b00, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd0, 32'h0, 32'hDEADBEEF, 1'b0};
    vecs[6] = '{3'b100, 32'h8, 32'h0, 1'b0, 32'h10000080, 5'd0, 2'b00, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h8, 32'hDEADBEEF, 1'b0};
    vecs[7] = '{3'b001, 32'h3, 32'h44444444, 1'b0, 32'h600, 5'd7, 2'b10, 1'b1, 32'h55555555,
                1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 5'd0, 32'h8, 32'hDEADBEEF, 1'b1};
    vecs[8] = '{3'b000, 32'h7C, 32'h0, 1'b1, 32'h700, 5'd31, 2'b11, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 5'd31, 32'h7C, 32'hDEADBEEF, 1'b0};
    vecs[9] = '{3'b010, 32'hFFFFFFFC, 32'h0, 1'b0, 32'h800, 5'd2, 2'b01, 1'b1, 32'h0F0F0F0F,
                1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 5'd2, 32'hFFFFFFFC, 32'h0F0F0F0F, 1'b0};

    // Reset for two cycles with arbitrary data on the inputs.
    rst = 1'b1;
    drive(3'b000, 32'h1234_5677, 32'hA5A5_A5A5, 1'b1, 32'h8000_0000, 5'd17, 2'b11, 1'b1,
          32'hFFFF_FFFF);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst read_data", o_read_data, 32'h0);
    chk("rst alu_result", o_alu_result, 32'h0);
    chk("rst write_reg", {27'h0, o_write_reg}, 32'h0);
    chk("rst WB_control", {30'h0, o_WB_control}, 32'h0);
    chk("rst misalign", {31'h0, o_misalign}, 32'h0);
    chk("rst bus_err", {31'h0, o_bus_err}, 32'h0);
    chk("rst dmem_req", {31'h0, o_dmem_req}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive_idle();

    // Single-cycle vectors, each starting from IDLE.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].ctrl, vecs[i].result, vecs[i].wdata, vecs[i].zero, vecs[i].bpc,
            vecs[i].wreg, vecs[i].wb, vecs[i].ack, vecs[i].rdata);
      #1;
      chk($sformatf("v%0d req", i), {31'h0, o_dmem_req}, {31'h0, vecs[i].e_req});
      chk($sformatf("v%0d we", i), {31'h0, o_dmem_we}, {31'h0, vecs[i].e_we});
      chk($sformatf("v%0d stall", i), {31'h0, o_stall}, {31'h0, vecs[i].e_stall});
      chk($sformatf("v%0d pc_src", i), {31'h0, o_pc_src}, {31'h0, vecs[i].e_pcsrc});
      chk($sformatf("v%0d branch_pc", i), o_branch_pc, vecs[i].bpc);
      chk($sformatf("v%0d addr", i), o_dmem_addr, vecs[i].result);
      chk($sformatf("v%0d wdata", i), o_dmem_wdata, vecs[i].wdata);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d WB", i), {30'h0, o_WB_control}, {30'h0, vecs[i].e_wb});
      chk($sformatf("v%0d write_reg", i), {27'h0, o_write_reg}, {27'h0, vecs[i].e_wreg});
      chk($sformatf("v%0d alu", i), o_alu_result, vecs[i].e_alu);
      chk($sformatf("v%0d read_data", i), o_read_data, vecs[i].e_rd);
      chk($sformatf("v%0d misalign", i), {31'h0, o_misalign}, {31'h0, vecs[i].e_mis});
      chk($sformatf("v%0d bus_err", i), {31'h0, o_bus_err}, 32'h0);
    end

    // sw acked in the 3rd request cycle: 3 request cycles, 2 stall cycles.
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) begin
        drive(3'b001, 32'h20, 32'h12345678, 1'b0, 32'h0, 5'd4, 2'b11, 1'b0, 32'h0);
      end
      i_dmem_ack = (c == 3);
      #1;
      chk($sformatf("sw c%0d req", c), {31'h0, o_dmem_req}, 32'h1);
      chk($sformatf("sw c%0d we", c), {31'h0, o_dmem_we}, 32'h1);
      chk($sformatf("sw c%0d stall", c), {31'h0, o_stall}, (c < 3) ? 32'h1 : 32'h0);
      @(posedge clk);
      #1;
      if (c < 3) begin
        chk($sformatf("sw c%0d WB bubble", c), {30'h0, o_WB_control}, 32'h0);
        chk($sformatf("sw c%0d alu held", c), o_alu_result, 32'hFFFFFFFC);
        chk($sformatf("sw c%0d wreg held", c), {27'h0, o_write_reg}, 32'd2);
      end else begin
        chk("sw done WB", {30'h0, o_WB_control}, 32'h3);
        chk("sw done wreg", {27'h0, o_write_reg}, 32'd4);
        chk("sw done alu", o_alu_result, 32'h20);
        chk("sw done read_data held", o_read_data, 32'h0F0F0F0F);
      end
    end
    @(negedge clk);
    drive_idle();
    #1;
    chk("sw after req", {31'h0, o_dmem_req}, 32'h0);

    // lw with two wait cycles; read data must only load on the ack.
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      drive(3'b010, 32'h30, 32'h0, 1'b0, 32'h0, 5'd6, 2'b01, (c == 3),
            (c == 3) ? 32'hA5A55A5A : 32'hFFFF0000);
      #1;
      chk($sformatf("lw c%0d req", c), {31'h0, o_dmem_req}, 32'h1);
      chk($sformatf("lw c%0d stall", c), {31'h0, o_stall}, (c < 3) ? 32'h1 : 32'h0);
      @(posedge clk);
      #1;
      if (c < 3) begin
        chk($sformatf("lw c%0d WB bubble", c), {30'h0, o_WB_control}, 32'h0);
        chk($sformatf("lw c%0d rd held", c), o_read_data, 32'h0F0F0F0F);
      end else begin
        chk("lw done WB", {30'h0, o_WB_control}, 32'h1);
        chk("lw done wreg", {27'h0, o_write_reg}, 32'd6);
        chk("lw done rd", o_read_data, 32'hA5A55A5A);
      end
    end
    @(negedge clk);
    drive_idle();

    // Reset asserted in the 2nd WAIT cycle abandons the access.
    @(negedge clk);
    drive(3'b010, 32'h50, 32'h0, 1'b0, 32'h0, 5'd9, 2'b11, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rstwait w1 req", {31'h0, o_dmem_req}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rstwait w2 req", {31'h0, o_dmem_req}, 32'h1);
    rst = 1'b1;
    drive_idle();
    @(posedge clk);
    #1;
    chk("rstwait req dropped", {31'h0, o_dmem_req}, 32'h0);
    chk("rstwait stall", {31'h0, o_stall}, 32'h0);
    chk("rstwait read_data", o_read_data, 32'h0);
    chk("rstwait alu", o_alu_result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstwait idle req", {31'h0, o_dmem_req}, 32'h0);

`ifdef MEM_TIMEOUT_EN
    // lw with no ack: 4 request cycles, then bus error and return to IDLE.
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        drive(3'b010, 32'h60, 32'h0, 1'b0, 32'h0, 5'd10, 2'b11, 1'b0, 32'h0);
      end
      #1;
      chk($sformatf("to c%0d req", c), {31'h0, o_dmem_req}, 32'h1);
      chk($sformatf("to c%0d stall", c), {31'h0, o_stall}, (c < 4) ? 32'h1 : 32'h0);
      @(posedge clk);
      #1;
      chk($sformatf("to c%0d bus_err", c), {31'h0, o_bus_err}, (c < 4) ? 32'h0 : 32'h1);
      chk($sformatf("to c%0d WB bubble", c), {30'h0, o_WB_control}, 32'h0);
    end
    @(negedge clk);
    drive(3'b000, 32'h0, 32'h0, 1'b0, 32'h0, 5'd0, 2'b00, 1'b1, 32'h77777777);
    #1;
    chk("to idle req", {31'h0, o_dmem_req}, 32'h0);
    chk("to idle stall", {31'h0, o_stall}, 32'h0);
    @(posedge clk);
    #1;
    chk("to bus_err pulse end", {31'h0, o_bus_err}, 32'h0);
    chk("to late ack ignored", o_read_data, 32'h0);
`else
    // Without the timeout option a request waits indefinitely.
    @(negedge clk);
    drive(3'b010, 32'h60, 32'h0, 1'b0, 32'h0, 5'd10, 2'b11, 1'b0, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      #1;
      chk($sformatf("nto c%0d req", c), {31'h0, o_dmem_req}, 32'h1);
      chk($sformatf("nto c%0d stall", c), {31'h0, o_stall}, 32'h1);
      @(posedge clk);
      #1;
      chk($sformatf("nto c%0d bus_err", c), {31'h0, o_bus_err}, 32'h0);
      @(negedge clk);
    end
    i_dmem_ack   = 1'b1;
    i_dmem_rdata = 32'h13572468;
    #1;
    chk("nto ack stall", {31'h0, o_stall}, 32'h0);
    @(posedge clk);
    #1;
    chk("nto done rd", o_read_data, 32'h13572468);
    chk("nto done WB", {30'h0, o_WB_control}, 32'h3);
`endif

    @(negedge clk);
    drive_idle();
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
